play_sequencer: RTL and testbench

Controller that sequences one play-mode run: it latches the selected song and runs a count-in. It then steps the note index through the song ROM, starts the sound generator on each note, and issues one score-commit pulse per finished note. It sits between the mode/top-level control and the song ROM, sound generator and scoring datapath, and replaces ad-hoc cnt/can_add bookkeeping with one FSM.

---
 rtl/play_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_play_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/play_sequencer.sv
// play_sequencer
//
// Sequences one play-mode run: latches the selected song, runs a count-in,
// then steps the note index through the song ROM. It starts the sound
// generator on every note and issues one score-commit pulse per finished note.
//
// Ports
//   clk         system clock, rising-edge
//   rst_n       synchronous active-low reset
//   en          play mode selected; low aborts to IDLE on the next edge
//   start       begin a run (honoured only in IDLE or DONE)
//   pause       level; freezes counters and FSM in COUNT/PLAY/GAP
//   song_sel    song to play
//   track       note count of the latched song (from song ROM)
//   over        sound generator reports the current note finished
//   song_out    latched song to song ROM
//   cnt         current note index to song ROM and scoring
//   note_start  1-cycle pulse: sound generator loads note cnt
//   sound_en    high in PLAY while not paused
//   commit      1-cycle pulse: scoring accumulates result for note cnt
//   countdown   remaining count-in ticks, 0 outside COUNT
//   busy        state is COUNT, PLAY or GAP
//   done        state is DONE
module play_sequencer #(
  parameter int SONG_BITS  = 3,
  parameter int CNT_BITS   = 6,
  parameter int TICK_DIV   = 25_000_000,
  parameter int COUNT_IN   = 3,
  parameter int GAP_CYCLES = 1_000_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 start,
  input  logic                 pause,
  input  logic [SONG_BITS-1:0] song_sel,
  input  logic [CNT_BITS-1:0]  track,
  input  logic                 over,
  output logic [SONG_BITS-1:0] song_out,
  output logic [CNT_BITS-1:0]  cnt,
  output logic                 note_start,
  output logic                 sound_en,
  output logic                 commit,
  output logic [1:0]           countdown,
  output logic                 busy,
  output logic                 done
);

  // One timer serves both the count-in tick and the inter-note gap; the two
  // phases never overlap.
  localparam int MAX_DIV = (TICK_DIV > GAP_CYCLES) ? TICK_DIV : GAP_CYCLES;
  localparam int TW      = (MAX_DIV > 2) ? $clog2(MAX_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    PLAY,
    GAP,
    DONE
  } state_e;

  state_e                state_q, state_d;
  logic [SONG_BITS-1:0]  song_q, song_d;
  logic [CNT_BITS-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [1:0]            cd_q, cd_d;
  logic                  note_start_q, note_start_d;
  logic                  commit_q, commit_d;
  logic                  sound_en_q, sound_en_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  // Extended by one bit so the last-note test cannot wrap.
  logic [CNT_BITS:0]     cnt_inc;
  logic [CNT_BITS:0]     track_ext;

  always_comb begin
    cnt_inc   = {1'b0, cnt_q} + (CNT_BITS+1)'(1);
    track_ext = {1'b0, track};

    state_d      = state_q;
    song_d       = song_q;
    cnt_d        = cnt_q;
    timer_d      = timer_q;
    cd_d         = cd_q;
    note_start_d = 1'b0;
    commit_d     = 1'b0;

    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      timer_d = '0;
      cd_d    = '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d = COUNT;
            song_d  = song_sel;
            cnt_d   = '0;
            timer_d = '0;
            cd_d    = 2'(COUNT_IN);
          end
        end

        COUNT: begin
          if (!pause) begin
            if (timer_q == TICK_LAST) begin
              timer_d = '0;
              cd_d    = cd_q - 2'd1;
              if (cd_q == 2'd1) begin
                if (track == '0) begin
                  state_d = DONE;
                end else begin
                  state_d      = PLAY;
                  note_start_d = 1'b1;
                end
              end
            end else begin
              timer_d = timer_q + TW'(1);
            end
          end
        end

        PLAY: begin
          // over is not trusted while note_start is still on the wire: the
          // generator has not loaded the new note yet.
          if (!pause && over && !note_start_q) begin
            state_d  = GAP;
            commit_d = 1'b1;
            timer_d  = '0;
          end
        end

        GAP: begin
          if (!pause) begin
            if (timer_q == GAP_LAST) begin
              timer_d = '0;
              if (cnt_inc == track_ext) begin
                state_d = DONE;
                cnt_d   = track;
              end else begin
                state_d      = PLAY;
                cnt_d        = cnt_inc[CNT_BITS-1:0];
                note_start_d = 1'b1;
              end
            end else begin
              timer_d = timer_q + TW'(1);
            end
          end
        end

        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          timer_d = '0;
          cd_d    = '0;
        end
      endcase
    end

    // Level outputs are decoded from the next state so they line up with
    // the registered state they describe.
    sound_en_d = (state_d == PLAY) && !pause;
    busy_d     = (state_d == COUNT) || (state_d == PLAY) || (state_d == GAP);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      song_q       <= '0;
      cnt_q        <= '0;
      timer_q      <= '0;
      cd_q         <= '0;
      note_start_q <= 1'b0;
      commit_q     <= 1'b0;
      sound_en_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      song_q       <= song_d;
      cnt_q        <= cnt_d;
      timer_q      <= timer_d;
      cd_q         <= cd_d;
      note_start_q <= note_start_d;
      commit_q     <= commit_d;
      sound_en_q   <= sound_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign song_out   = song_q;
  assign cnt        = cnt_q;
  assign note_start = note_start_q;
  assign sound_en   = sound_en_q;
  assign commit     = commit_q;
  assign countdown  = cd_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_play_sequencer.sv
module tb_play_sequencer;

  localparam int SB = 3;
  localparam int CB = 6;
  localparam int TD = 4;
  localparam int CI = 3;
  localparam int GC = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          start = 1'b0;
  logic          pause = 1'b0;
  logic          over = 1'b0;
  logic [SB-1:0] song_sel = '0;
  logic [CB-1:0] track = '0;
  logic [SB-1:0] song_out;
  logic [CB-1:0] cnt;
  logic          note_start;
  logic          sound_en;
  logic          commit;
  logic [1:0]    countdown;
  logic          busy;
  logic          done;

  int vectors = 0;
  int miscompares = 0;

  // kind: 0 = note_start, 1 = commit, 2 = done
  typedef struct {
    int kind;
    int cnt;
    int cyc;
  } ev_t;

  ev_t sb[$];

  play_sequencer #(
    .SONG_BITS (SB),
    .CNT_BITS  (CB),
    .TICK_DIV  (TD),
    .COUNT_IN  (CI),
    .GAP_CYCLES(GC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .start     (start),
    .pause     (pause),
    .song_sel  (song_sel),
    .track     (track),
    .over      (over),
    .song_out  (song_out),
    .cnt       (cnt),
    .note_start(note_start),
    .sound_en  (sound_en),
    .commit    (commit),
    .countdown (countdown),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; en = 1'b1; start = 1'b1; song_sel = 3'd5; track = 6'd3;
    @(negedge clk);
    vectors++;
    if (song_out !== '0) begin miscompares++; $display("FAIL reset_song: got %0d want 0", song_out); end
    vectors++;
    if (cnt !== '0) begin miscompares++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
    vectors++;
    if (countdown !== 2'd0) begin miscompares++; $display("FAIL reset_countdown: got %0d want 0", countdown); end
    vectors++;
    if ({note_start, sound_en, commit, busy, done} !== 5'b0)
      begin miscompares++; $display("FAIL reset_flags: got %b want 00000", {note_start, sound_en, commit, busy, done}); end
    rst_n = 1'b1; start = 1'b0;
    @(negedge clk);
    vectors++;
    if ({busy, done, note_start, cnt} !== 9'b0)
      begin miscompares++; $display("FAIL reset_idle_hold: got busy=%b done=%b ns=%b cnt=%0d want all 0", busy, done, note_start, cnt); end
  endtask

  // Starts a run from IDLE/DONE and follows it to DONE, checking every pulse
  // against a scoreboard of expected (kind, cnt, cycle) events.
  task automatic do_run(input string name, input int trk, input int sng, input bit hold);
    int  base, per, done_cyc, cyc, exp_cd;
    bit  over_next, exp_se, exp_busy;
    ev_t e, x;
    base = CI * TD + 1;
    per  = 2 + GC;
    done_cyc = (trk == 0) ? base : base + trk * per;
    for (int n = 0; n < trk; n++) begin
      e.kind = 0; e.cnt = n; e.cyc = base + n * per;     sb.push_back(e);
      e.kind = 1; e.cnt = n; e.cyc = base + n * per + 2; sb.push_back(e);
    end
    e.kind = 2; e.cnt = trk; e.cyc = done_cyc; sb.push_back(e);

    @(negedge clk);
    en = 1'b1; start = 1'b1; pause = 1'b0; over = 1'b0;
    song_sel = SB'(sng); track = CB'(trk);
    over_next = 1'b0;
    cyc = 0;
    while (cyc < 400 && sb.size() > 0) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc == 1) begin
        vectors++;
        if (song_out !== SB'(sng)) begin miscompares++; $display("FAIL %s_song_out: got %0d want %0d", name, song_out, sng); end
        vectors++;
        if (cnt !== '0) begin miscompares++; $display("FAIL %s_cnt_start: got %0d want 0", name, cnt); end
      end
      if (cyc <= base) begin
        exp_cd = (cyc <= CI * TD) ? CI - (cyc - 1) / TD : 0;
        vectors++;
        if (int'(countdown) !== exp_cd)
          begin miscompares++; $display("FAIL %s_countdown c%0d: got %0d want %0d", name, cyc, countdown, exp_cd); end
      end
      exp_se = (trk > 0) && (cyc >= base) && ((cyc - base) / per < trk) && ((cyc - base) % per < 2);
      vectors++;
      if (sound_en !== exp_se)
        begin miscompares++; $display("FAIL %s_sound_en c%0d: got %b want %b", name, cyc, sound_en, exp_se); end
      exp_busy = (cyc < done_cyc);
      vectors++;
      if (busy !== exp_busy)
        begin miscompares++; $display("FAIL %s_busy c%0d: got %b want %b", name, cyc, busy, exp_busy); end
      if (note_start || commit || done) begin
        e.kind = note_start ? 0 : (commit ? 1 : 2);
        e.cnt  = int'(cnt);
        e.cyc  = cyc;
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL %s_unexpected_event: got kind=%0d cnt=%0d c%0d want none", name, e.kind, e.cnt, e.cyc);
        end else begin
          x = sb.pop_front();
          if (e.kind !== x.kind || e.cnt !== x.cnt || e.cyc !== x.cyc) begin
            miscompares++;
            $display("FAIL %s_event: got kind=%0d cnt=%0d c%0d want kind=%0d cnt=%0d c%0d",
                     name, e.kind, e.cnt, e.cyc, x.kind, x.cnt, x.cyc);
          end
        end
      end
      if (hold) begin
        over = 1'b1;
      end else begin
        over = over_next;
        over_next = note_start;
      end
    end
    over = 1'b0;
    if (sb.size() != 0) begin
      vectors++; miscompares++;
      $display("FAIL %s_timeout: got %0d events pending want 0", name, sb.size());
      sb.delete();
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b1 || int'(cnt) !== trk || busy !== 1'b0)
      begin miscompares++; $display("FAIL %s_final: got done=%b cnt=%0d busy=%b want 1 %0d 0", name, done, cnt, busy, trk); end
  endtask

  task automatic test_full_run();
    do_run("full_run", 3, 3, 1'b0);
  endtask

  task automatic test_abort();
    bit found, over_next;
    int pulses;
    found = 1'b0; over_next = 1'b0;
    @(negedge clk);
    en = 1'b1; start = 1'b1; song_sel = 3'd3; track = 6'd3; over = 1'b0; pause = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      start = 1'b0;
      over = over_next;
      over_next = note_start;
      if (commit && cnt == 6'd1) begin
        en = 1'b0; over = 1'b0; found = 1'b1;
      end
    end
    vectors++;
    if (!found) begin miscompares++; $display("FAIL abort_reach_gap: got no commit at cnt=1 want one"); end
    @(negedge clk);
    vectors++;
    if ({busy, done, note_start, commit, sound_en} !== 5'b0)
      begin miscompares++; $display("FAIL abort_flags: got %b want 00000", {busy, done, note_start, commit, sound_en}); end
    vectors++;
    if (cnt !== '0 || countdown !== 2'd0)
      begin miscompares++; $display("FAIL abort_cnt: got cnt=%0d cd=%0d want 0 0", cnt, countdown); end
    vectors++;
    if (song_out !== 3'd3) begin miscompares++; $display("FAIL abort_song_hold: got %0d want 3", song_out); end
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) en = 1'b1;
      @(negedge clk);
      if (note_start || commit || busy || done) pulses++;
    end
    vectors++;
    if (pulses !== 0) begin miscompares++; $display("FAIL abort_quiet: got %0d active cycles want 0", pulses); end
  endtask

  task automatic test_track_zero();
    do_run("track_zero", 0, 2, 1'b0);
  endtask

  task automatic test_restart_from_done();
    do_run("restart", 2, 5, 1'b1);
  endtask

  task automatic test_over_held();
    do_run("over_held", 4, 6, 1'b1);
  endtask

  task automatic test_pause();
    bit found;
    found = 1'b0;
    @(negedge clk);
    en = 1'b1; start = 1'b1; song_sel = 3'd1; track = 6'd1; over = 1'b0; pause = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (note_start) found = 1'b1;
    end
    vectors++;
    if (!found) begin miscompares++; $display("FAIL pause_reach_play: got no note_start want one"); end
    @(negedge clk);
    vectors++;
    if (sound_en !== 1'b1) begin miscompares++; $display("FAIL pause_sound_before: got %b want 1", sound_en); end
    pause = 1'b1; over = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      vectors++;
      if (commit !== 1'b0 || sound_en !== 1'b0 || busy !== 1'b1)
        begin miscompares++; $display("FAIL pause_hold%0d: got commit=%b se=%b busy=%b want 0 0 1", i, commit, sound_en, busy); end
      if (i == 5) pause = 1'b0;
    end
    @(negedge clk);
    over = 1'b0;
    vectors++;
    if (commit !== 1'b1 || cnt !== '0)
      begin miscompares++; $display("FAIL pause_commit: got commit=%b cnt=%0d want 1 0", commit, cnt); end
    repeat (GC) @(negedge clk);
    vectors++;
    if (done !== 1'b1 || cnt !== 6'd1)
      begin miscompares++; $display("FAIL pause_done: got done=%b cnt=%0d want 1 1", done, cnt); end
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_abort();
    test_track_zero();
    test_restart_from_done();
    test_pause();
    test_over_held();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
